// File: rtl/lifo_fifo_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lifo_fifo_top
//
// Single-port-array storage that behaves as either a FIFO or a LIFO (stack).
// One opcode is accepted every clock: NOP, POP, PUSH, or PUSH+POP in the same
// cycle. Pop results are registered, so they appear one cycle after the
// opcode edge and are marked by a one-cycle data_valid pulse.
//
// The operating mode can only change while the store is empty and idle (NOP).
// This prevents entries written in one ordering discipline from being read
// back in the other. Both pointers are cleared whenever the mode flips.
//
// Parameters
//   DATA_WIDTH : width of one entry
//   DEPTH      : entry count, power of 2 in 2..256
//   CNT_WIDTH  : occupancy counter width, derived as log2(DEPTH)+1
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous, active-high reset
//   vector_in    : [DATA_WIDTH+1:DATA_WIDTH] opcode, [DATA_WIDTH-1:0] push data
//   mode         : requested mode, 0 = FIFO, 1 = LIFO
//   data_out     : registered pop result (holds when no pop succeeds)
//   data_valid   : one-cycle pulse marking a new data_out
//   empty        : count == 0
//   full         : count == DEPTH
//   count        : current occupancy
//   overflow     : one-cycle pulse, push rejected because full
//   underflow    : one-cycle pulse, pop rejected because empty
//   mode_active  : mode currently in effect
// -----------------------------------------------------------------------------
module lifo_fifo_top #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH+1:0] vector_in,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  mode_active
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_POP      = 2'b01,
        OP_PUSH     = 2'b10,
        OP_PUSH_POP = 2'b11
    } op_t;

    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } mode_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    mode_t                 mode_q,       mode_d;
    logic [PTR_WIDTH-1:0]  rd_ptr,       rd_ptr_d;
    logic [PTR_WIDTH-1:0]  wr_ptr,       wr_ptr_d;
    logic [CNT_WIDTH-1:0]  count_d;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic                  data_valid_d;
    logic                  overflow_d;
    logic                  underflow_d;

    // Storage write port, driven from the next-state logic
    logic                  mem_we;
    logic [PTR_WIDTH-1:0]  mem_waddr;

    // -------------------------------------------------------------------------
    // Input decode
    // -------------------------------------------------------------------------
    op_t                   op;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_req;
    logic                  pop_req;
    logic                  pop_ok;
    logic                  push_ok;
    logic [PTR_WIDTH-1:0]  top_ptr;
    logic [PTR_WIDTH-1:0]  rd_addr;

    assign op        = op_t'(vector_in[DATA_WIDTH+1:DATA_WIDTH]);
    assign push_data = vector_in[DATA_WIDTH-1:0];
    assign push_req  = (op == OP_PUSH) || (op == OP_PUSH_POP);
    assign pop_req   = (op == OP_POP)  || (op == OP_PUSH_POP);

    // Flags come from the count register alone, never from the pointers,
    // because in FIFO mode rd_ptr == wr_ptr for both empty and full.
    assign empty = (count == '0);
    assign full  = (count == CNT_WIDTH'(DEPTH));

    // A pop needs data. A push needs a free slot, unless a pop in the same
    // cycle frees one; that lets PUSH+POP proceed when full.
    assign pop_ok  = pop_req && !empty;
    assign push_ok = push_req && (!full || pop_ok);

    // Top of stack sits one below wr_ptr. At full, wr_ptr has wrapped to 0,
    // so the modulo subtraction lands on DEPTH-1 as required.
    assign top_ptr = wr_ptr - PTR_WIDTH'(1);
    assign rd_addr = (mode_q == MODE_LIFO) ? top_ptr : rd_ptr;

    assign mode_active = mode_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        mode_d       = mode_q;
        rd_ptr_d     = rd_ptr;
        wr_ptr_d     = wr_ptr;
        count_d      = count;
        data_out_d   = data_out;
        data_valid_d = 1'b0;
        overflow_d   = push_req && !push_ok;
        underflow_d  = pop_req && empty;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr;

        if (pop_ok) begin
            data_out_d   = mem[rd_addr];
            data_valid_d = 1'b1;
        end

        unique case (mode_q)
            MODE_FIFO: begin
                if (pop_ok) begin
                    rd_ptr_d = rd_ptr + PTR_WIDTH'(1);
                end
                if (push_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr;
                    wr_ptr_d  = wr_ptr + PTR_WIDTH'(1);
                end
            end

            MODE_LIFO: begin
                if (push_ok && pop_ok) begin
                    // Replace the top entry in place; the old value is read
                    // out this cycle, so the stack height does not move.
                    mem_we    = 1'b1;
                    mem_waddr = top_ptr;
                end else if (push_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr;
                    wr_ptr_d  = wr_ptr + PTR_WIDTH'(1);
                end else if (pop_ok) begin
                    wr_ptr_d  = top_ptr;
                end
            end

            default: ;
        endcase

        if (push_ok && !pop_ok) begin
            count_d = count + CNT_WIDTH'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count - CNT_WIDTH'(1);
        end

        // The mode may only change while empty and idle. Clearing both
        // pointers gives the new discipline a clean starting point.
        if (op == OP_NOP && empty && mode_t'(mode) != mode_q) begin
            mode_d   = mode_t'(mode);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values computed above.
        if (reset) begin
            mode_q     <= MODE_FIFO;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            rd_ptr     <= rd_ptr_d;
            wr_ptr     <= wr_ptr_d;
            count      <= count_d;
            data_out   <= data_out_d;
            data_valid <= data_valid_d;
            overflow   <= overflow_d;
            underflow  <= underflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset. Stale contents are never visible, because
    // a read only happens when count says the slot holds a live entry.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= push_data;
        end
    end

endmodule

// File: tb/tb_lifo_fifo_top.sv
`timescale 1ns/1ps
module tb_lifo_fifo_top;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] POP = 2'b01;
    localparam logic [1:0] PSH = 2'b10;
    localparam logic [1:0] PP  = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW+1:0] vector_in;
    logic          mode;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          mode_active;

    int tests = 0;
    int fails = 0;

    lifo_fifo_top #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .vector_in   (vector_in),
        .mode        (mode),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .mode_active (mode_active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Reference model: a queue of entries; FIFO pops the front, LIFO the back.
    // -------------------------------------------------------------------------
    logic [DW-1:0] q [$];
    logic          m_mode  = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_valid = 1'b0;
    logic          m_ov    = 1'b0;
    logic          m_un    = 1'b0;

    task automatic model_step(input logic [1:0] op, input logic [DW-1:0] d,
                              input logic m, input logic r);
        int sz;
        m_valid = 1'b0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
        if (r) begin
            q.delete();
            m_data = '0;
            m_mode = 1'b0;
            return;
        end
        sz = q.size();
        if (op[0]) begin
            if (sz == 0) m_un = 1'b1;
            else begin
                m_valid = 1'b1;
                m_data  = m_mode ? q.pop_back() : q.pop_front();
            end
        end
        if (op[1]) begin
            if (sz == DEPTH && !op[0]) m_ov = 1'b1;
            else q.push_back(d);
        end
        if (op == NOP && sz == 0) m_mode = m;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"},  32'(data_out),    32'(m_data));
        check({tag, "_valid"}, 32'(data_valid),  32'(m_valid));
        check({tag, "_ovf"},   32'(overflow),    32'(m_ov));
        check({tag, "_unf"},   32'(underflow),   32'(m_un));
        check({tag, "_count"}, 32'(count),       32'(q.size()));
        check({tag, "_empty"}, 32'(empty),       32'(q.size() == 0));
        check({tag, "_full"},  32'(full),        32'(q.size() == DEPTH));
        check({tag, "_mode"},  32'(mode_active), 32'(m_mode));
    endtask

    // Drive one opcode, let one edge pass, sample 1 ns after it.
    task automatic drive(input logic [1:0] op, input logic [DW-1:0] d,
                         input logic m, input logic r);
        vector_in = {op, d};
        mode      = m;
        reset     = r;
        @(posedge clk);
        #1;
    endtask

    // Drive, advance the model, compare everything against it.
    task automatic cyc(input string tag, input logic [1:0] op, input logic [DW-1:0] d,
                       input logic m, input logic r);
        drive(op, d, m, r);
        model_step(op, d, m, r);
        check_model(tag);
    endtask

    // -------------------------------------------------------------------------
    // Directed vectors with hand-derived expectations
    // -------------------------------------------------------------------------
    typedef struct {
        logic          rst;
        logic [1:0]    op;
        logic [DW-1:0] din;
        logic          md;
        logic [DW-1:0] e_data;
        logic          e_valid;
        logic [CW-1:0] e_count;
        logic          e_ov;
        logic          e_un;
        logic          e_mode;
    } vec_t;

    vec_t vecs [20];

    initial begin
        reset     = 1'b1;
        vector_in = '0;
        mode      = 1'b0;

        //            rst  op   din    md   data   v  cnt ov un mode
        // FIFO fill, overflow, drain
        vecs[0]  = '{1'b1, NOP, 8'h00, 1'b0, 8'h00, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, PSH, 8'h11, 1'b0, 8'h00, 0, 1, 0, 0, 0};
        vecs[2]  = '{1'b0, PSH, 8'h22, 1'b0, 8'h00, 0, 2, 0, 0, 0};
        vecs[3]  = '{1'b0, PSH, 8'h33, 1'b0, 8'h00, 0, 3, 0, 0, 0};
        vecs[4]  = '{1'b0, PSH, 8'h44, 1'b0, 8'h00, 0, 4, 0, 0, 0};
        vecs[5]  = '{1'b0, PSH, 8'h55, 1'b0, 8'h00, 0, 4, 1, 0, 0};
        vecs[6]  = '{1'b0, POP, 8'h00, 1'b0, 8'h11, 1, 3, 0, 0, 0};
        vecs[7]  = '{1'b0, POP, 8'h00, 1'b0, 8'h22, 1, 2, 0, 0, 0};
        vecs[8]  = '{1'b0, POP, 8'h00, 1'b0, 8'h33, 1, 1, 0, 0, 0};
        vecs[9]  = '{1'b0, POP, 8'h00, 1'b0, 8'h44, 1, 0, 0, 0, 0};
        // LIFO order, underflow, PUSH+POP on empty
        vecs[10] = '{1'b0, NOP, 8'h00, 1'b1, 8'h44, 0, 0, 0, 0, 1};
        vecs[11] = '{1'b0, PSH, 8'hA1, 1'b1, 8'h44, 0, 1, 0, 0, 1};
        vecs[12] = '{1'b0, PSH, 8'hA2, 1'b1, 8'h44, 0, 2, 0, 0, 1};
        vecs[13] = '{1'b0, PSH, 8'hA3, 1'b1, 8'h44, 0, 3, 0, 0, 1};
        vecs[14] = '{1'b0, POP, 8'h00, 1'b1, 8'hA3, 1, 2, 0, 0, 1};
        vecs[15] = '{1'b0, POP, 8'h00, 1'b1, 8'hA2, 1, 1, 0, 0, 1};
        vecs[16] = '{1'b0, POP, 8'h00, 1'b1, 8'hA1, 1, 0, 0, 0, 1};
        vecs[17] = '{1'b0, POP, 8'h00, 1'b1, 8'hA1, 0, 0, 0, 1, 1};
        vecs[18] = '{1'b0, PP,  8'h5A, 1'b1, 8'hA1, 0, 1, 0, 1, 1};
        vecs[19] = '{1'b0, POP, 8'h00, 1'b1, 8'h5A, 1, 0, 0, 0, 1};

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].op, vecs[i].din, vecs[i].md, vecs[i].rst);
            check($sformatf("vec%0d_data", i),  32'(data_out),    32'(vecs[i].e_data));
            check($sformatf("vec%0d_valid", i), 32'(data_valid),  32'(vecs[i].e_valid));
            check($sformatf("vec%0d_count", i), 32'(count),       32'(vecs[i].e_count));
            check($sformatf("vec%0d_ovf", i),   32'(overflow),    32'(vecs[i].e_ov));
            check($sformatf("vec%0d_unf", i),   32'(underflow),   32'(vecs[i].e_un));
            check($sformatf("vec%0d_mode", i),  32'(mode_active), 32'(vecs[i].e_mode));
            check($sformatf("vec%0d_empty", i), 32'(empty),       32'(vecs[i].e_count == 0));
            check($sformatf("vec%0d_full", i),  32'(full),        32'(vecs[i].e_count == DEPTH));
        end

        // ---------------------------------------------------------------------
        // Simultaneous PUSH+POP, FIFO
        // ---------------------------------------------------------------------
        cyc("sf_rst", NOP, 8'h00, 1'b0, 1'b1);
        cyc("sf_p1",  PSH, 8'h01, 1'b0, 1'b0);
        cyc("sf_p2",  PSH, 8'h02, 1'b0, 1'b0);
        cyc("sf_pp",  PP,  8'h03, 1'b0, 1'b0);
        check("sf_pp_data_k", 32'(data_out), 32'h01);
        check("sf_pp_cnt_k",  32'(count),    32'd2);
        cyc("sf_r1",  POP, 8'h00, 1'b0, 1'b0);
        check("sf_r1_k", 32'(data_out), 32'h02);
        cyc("sf_r2",  POP, 8'h00, 1'b0, 1'b0);
        check("sf_r2_k", 32'(data_out), 32'h03);

        // Simultaneous PUSH+POP, LIFO
        cyc("sl_rst", NOP, 8'h00, 1'b0, 1'b1);
        cyc("sl_md",  NOP, 8'h00, 1'b1, 1'b0);
        cyc("sl_p1",  PSH, 8'h01, 1'b1, 1'b0);
        cyc("sl_p2",  PSH, 8'h02, 1'b1, 1'b0);
        cyc("sl_pp",  PP,  8'h03, 1'b1, 1'b0);
        check("sl_pp_data_k", 32'(data_out), 32'h02);
        check("sl_pp_cnt_k",  32'(count),    32'd2);
        cyc("sl_r1",  POP, 8'h00, 1'b1, 1'b0);
        check("sl_r1_k", 32'(data_out), 32'h03);
        cyc("sl_r2",  POP, 8'h00, 1'b1, 1'b0);
        check("sl_r2_k", 32'(data_out), 32'h01);

        // LIFO full + PUSH+POP: top slot wraps to DEPTH-1
        for (int i = 0; i < DEPTH; i++) cyc("slf_p", PSH, 8'(8'hC0 + i), 1'b1, 1'b0);
        cyc("slf_pp", PP, 8'hCC, 1'b1, 1'b0);
        check("slf_pp_data_k", 32'(data_out), 32'hC3);
        check("slf_pp_ovf_k",  32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) cyc("slf_d", POP, 8'h00, 1'b1, 1'b0);

        // FIFO full + PUSH+POP: no overflow, count stays DEPTH
        cyc("ff_rst", NOP, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc("ff_p", PSH, 8'(8'h70 + i), 1'b0, 1'b0);
        cyc("ff_pp", PP, 8'h99, 1'b0, 1'b0);
        check("ff_pp_ovf_k",  32'(overflow), 32'd0);
        check("ff_pp_cnt_k",  32'(count),    32'd4);
        check("ff_pp_data_k", 32'(data_out), 32'h70);
        for (int i = 0; i < DEPTH; i++) cyc("ff_d", POP, 8'h00, 1'b0, 1'b0);

        // ---------------------------------------------------------------------
        // FIFO wrap: alternating push/pop, pointers cycle several times
        // ---------------------------------------------------------------------
        cyc("wr_rst", NOP, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc("wr_push", PSH, 8'(i), 1'b0, 1'b0);
            cyc("wr_pop",  POP, 8'h00, 1'b0, 1'b0);
            check($sformatf("wr%0d_data_k", i), 32'(data_out), 32'(i));
            check($sformatf("wr%0d_cnt_k", i),  32'(count),    32'd0);
        end

        // ---------------------------------------------------------------------
        // Mode lock while non-empty, then reset mid-operation
        // ---------------------------------------------------------------------
        cyc("ml_rst", NOP, 8'h00, 1'b0, 1'b1);
        cyc("ml_p1",  PSH, 8'hB1, 1'b0, 1'b0);
        cyc("ml_p2",  PSH, 8'hB2, 1'b0, 1'b0);
        cyc("ml_t1",  NOP, 8'h00, 1'b1, 1'b0);
        check("ml_t1_mode_k", 32'(mode_active), 32'd0);
        cyc("ml_t2",  NOP, 8'h00, 1'b0, 1'b0);
        cyc("ml_t3",  NOP, 8'h00, 1'b1, 1'b0);
        check("ml_t3_mode_k", 32'(mode_active), 32'd0);
        cyc("ml_p3",  PSH, 8'hB3, 1'b1, 1'b0);
        cyc("ml_pop", POP, 8'h00, 1'b1, 1'b0);
        check("ml_pop_k", 32'(data_out), 32'hB1);
        cyc("ml_rst2", PSH, 8'hEE, 1'b1, 1'b1);
        check("ml_rst2_cnt_k",   32'(count),       32'd0);
        check("ml_rst2_empty_k", 32'(empty),       32'd1);
        check("ml_rst2_data_k",  32'(data_out),    32'd0);
        check("ml_rst2_mode_k",  32'(mode_active), 32'd0);
        cyc("ml_upop", POP, 8'h00, 1'b0, 1'b0);
        check("ml_upop_unf_k", 32'(underflow),  32'd1);
        check("ml_upop_val_k", 32'(data_valid), 32'd0);

        // ---------------------------------------------------------------------
        // Randomised traffic against the model
        // ---------------------------------------------------------------------
        cyc("rnd_rst", NOP, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 800; i++) begin
            int            sel;
            logic [1:0]    op;
            logic [DW-1:0] d;
            logic          m;
            logic          r;
            sel = int'($urandom_range(0, 9));
            op  = (sel < 2) ? NOP : (sel < 5) ? POP : (sel < 8) ? PSH : PP;
            d   = 8'($urandom);
            m   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 99) == 0);
            cyc($sformatf("rnd%0d", i), op, d, m, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lifo_fifo_top.md
LIFO_FIFO_TOP -- requirements
Module: lifo_fifo_top

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of one data entry.
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count; legal values are powers of 2 from 2 to 256.
REQ-003 Parameter CNT_WIDTH, default log2(DEPTH)+1, SHALL set the occupancy counter width; it is derived and not overridden.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 vector_in  input  DATA_WIDTH+2  bits [DATA_WIDTH+1:DATA_WIDTH] carry the opcode; the low DATA_WIDTH bits carry push data.
REQ-007 mode  input  1  requested mode: 0 = FIFO, 1 = LIFO.
REQ-008 data_out  output  DATA_WIDTH  registered pop result.
REQ-009 data_valid  output  1  one-cycle pulse marking a new data_out.
REQ-010 empty  output  1  high when count == 0.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 count  output  CNT_WIDTH  current occupancy.
REQ-013 overflow  output  1  one-cycle pulse for a rejected push.
REQ-014 underflow  output  1  one-cycle pulse for a rejected pop.
REQ-015 mode_active  output  1  registered mode in effect.

Function
REQ-016 The opcode SHALL decode as: 00 = NOP, 01 = POP, 10 = PUSH, 11 = PUSH+POP in the same cycle.
REQ-017 The opcode SHALL be sampled every rising edge, and the operation SHALL use mode_active as it stood before that edge.
REQ-018 Pop results SHALL appear on data_out with data_valid = 1 in the cycle after the opcode edge; when no pop succeeds, data_out SHALL hold its value and data_valid SHALL be 0.
REQ-019 FIFO mode: pop SHALL return the oldest entry, and push SHALL write at wr_ptr; rd_ptr and wr_ptr SHALL wrap modulo DEPTH.
REQ-020 LIFO mode: push SHALL write at wr_ptr and increment it; pop SHALL return entry wr_ptr-1 and decrement wr_ptr.
REQ-021 PUSH when full SHALL leave memory, pointers and count unchanged and SHALL pulse overflow.
REQ-022 POP when empty SHALL leave state unchanged and SHALL pulse underflow.
REQ-023 PUSH+POP when non-empty SHALL complete both operations with count unchanged, including when full; overflow SHALL NOT pulse in that case.
REQ-024 FIFO PUSH+POP SHALL return the oldest entry and write the new data at the tail.
REQ-025 LIFO PUSH+POP SHALL return the current top and write the new data into the same slot, with wr_ptr unchanged.
REQ-026 PUSH+POP when empty SHALL perform the push only, pulse underflow, and keep data_valid = 0.
REQ-027 mode_active SHALL load mode only on an edge where count == 0 and the opcode is NOP; otherwise mode SHALL be ignored.
REQ-028 When mode_active changes value, rd_ptr and wr_ptr SHALL clear to 0.
REQ-029 empty and full SHALL be decoded combinationally from the count register only.
REQ-030 Count SHALL increment by 1 on a successful push alone, decrement by 1 on a successful pop alone, and never leave the range 0..DEPTH.

Reset
REQ-031 While reset = 1 at an edge, the opcode SHALL be ignored and the block SHALL set: count = 0, rd_ptr = wr_ptr = 0, data_out = 0, data_valid = 0, overflow = 0, underflow = 0, mode_active = 0.
REQ-032 Storage contents SHALL NOT be reset, and no reset value SHALL be observable through data_out.
REQ-033 Reset asserted mid-operation SHALL discard all entries; the first pop after reset SHALL pulse underflow.

Verification (DATA_WIDTH=8, DEPTH=4)
REQ-034 FIFO fill/drain: PUSH 0x11, 0x22, 0x33, 0x44 -> full = 1, count = 4; PUSH 0x55 -> overflow pulse, count stays 4; POP x4 -> 0x11, 0x22, 0x33, 0x44, each one cycle later with data_valid = 1, then empty = 1.
REQ-035 LIFO order: mode = 1, NOP while empty -> mode_active = 1; PUSH 0xA1, 0xA2, 0xA3; POP x3 -> 0xA3, 0xA2, 0xA1; a 4th POP -> underflow pulse, data_valid = 0, data_out holds 0xA1.
REQ-036 Simultaneous operation: with 0x01, 0x02 stored, PUSH+POP 0x03 gives FIFO -> data_out 0x01, then pops 0x02, 0x03, and LIFO -> data_out 0x02, then pops 0x03, 0x01; count = 2 after the PUSH+POP in both modes; FIFO full + PUSH+POP -> no overflow, count stays 4.
REQ-037 FIFO wrap: 10 alternating PUSH/POP pairs with data 0x00..0x09 -> outputs in order 0x00..0x09, count never exceeds 1, pointers wrap without error.
REQ-038 Mode lock and reset: with 2 entries in FIFO, toggle mode -> mode_active stays 0; push a 3rd entry, then assert reset for 1 cycle -> count = 0, empty = 1, all outputs at reset values; POP -> underflow pulse.
